// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus-length definitions for the SRAM-like memory ports and the
// requester-ID encoding used by the instruction/data port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int SIZE_W        = 2;
    localparam int STRB_W        = 4;
    localparam int OUTSTANDING_W = 3;

    typedef enum logic {
        INST_ID = 1'b0,
        DATA_ID = 1'b1
    } req_id_e;

    // One SRAM-like request, bundled so the port mux is a single select.
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transactions.
// Pointers wrap modulo DEPTH; push when full and pop when empty are ignored.
module id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; a slot is only read after it was
    // written, because the count gates every use of head.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store SRAM-like ports onto one downstream port,
// holding the grant while a request waits and routing responses back in order.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                     clk,
    input  logic                     resetn,

    input  logic                     inst_req,
    input  logic                     inst_wr,
    input  logic [SIZE_W-1:0]        inst_size,
    input  logic [STRB_W-1:0]        inst_wstrb,
    input  logic [ADDR_W-1:0]        inst_addr,
    input  logic [DATA_W-1:0]        inst_wdata,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    output logic [DATA_W-1:0]        inst_rdata,

    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [SIZE_W-1:0]        data_size,
    input  logic [STRB_W-1:0]        data_wstrb,
    input  logic [ADDR_W-1:0]        data_addr,
    input  logic [DATA_W-1:0]        data_wdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    output logic [DATA_W-1:0]        data_rdata,

    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [SIZE_W-1:0]        mem_size,
    output logic [STRB_W-1:0]        mem_wstrb,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    input  logic [DATA_W-1:0]        mem_rdata,

    output logic [OUTSTANDING_W-1:0] outstanding,
    output logic                     resp_err
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

    mem_req_t                 inst_fields;
    mem_req_t                 data_fields;
    mem_req_t                 mem_fields;
    req_id_e                  grant;
    req_id_e                  lock_id;
    req_id_e                  head_id;
    logic                     lock_valid;
    logic [STARVE_W-1:0]      starve_cnt;
    logic                     sel_req;
    logic                     mem_xfer;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     fifo_head;
    logic [OUTSTANDING_W-1:0] fifo_count;

    assign inst_fields = '{inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_fields = '{data_wr, data_size, data_wstrb, data_addr, data_wdata};

    // NOTE: every always_comb output gets a default on its first line so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        grant = INST_ID;
        if (lock_valid)
            grant = lock_id;
        else if (starve_cnt == STARVE_MAX && inst_req)
            grant = INST_ID;
        else if (data_req)
            grant = DATA_ID;
    end

    assign sel_req    = (grant == DATA_ID) ? data_req : inst_req;
    assign mem_fields = (grant == DATA_ID) ? data_fields : inst_fields;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    assign mem_req  = resetn & sel_req & ~fifo_full;
    assign mem_xfer = mem_req & mem_addr_ok;

    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_fields;

    assign inst_addr_ok = mem_xfer & (grant == INST_ID);
    assign data_addr_ok = mem_xfer & (grant == DATA_ID);

    assign fifo_pop     = resetn & mem_data_ok & ~fifo_empty;
    assign head_id      = req_id_e'(fifo_head);
    assign inst_data_ok = fifo_pop & (head_id == INST_ID);
    assign data_data_ok = fifo_pop & (head_id == DATA_ID);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;
    assign outstanding  = fifo_count;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1),
        .CNT_W (OUTSTANDING_W)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (mem_xfer),
        .push_data (grant),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_valid <= 1'b0;
            lock_id    <= INST_ID;
            starve_cnt <= '0;
            resp_err   <= 1'b0;
        end else begin
            // A dropped request releases the lock even though that is a protocol violation.
            if (!sel_req)
                lock_valid <= 1'b0;
            else if (mem_req && !mem_addr_ok) begin
                lock_valid <= 1'b1;
                lock_id    <= grant;
            end else if (mem_xfer)
                lock_valid <= 1'b0;

            if (!inst_req || (mem_xfer && grant == INST_ID))
                starve_cnt <= '0;
            else if (mem_xfer && grant == DATA_ID && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + STARVE_ONE;

            if (mem_data_ok && fifo_empty)
                resp_err <= 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered downstream transactions (1..4).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive data grants allowed while inst_req is pending.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 inst_req/inst_wr  input  1/1  fetch-side request and write flag.
REQ-006 inst_size/inst_wstrb  input  2/4  fetch-side byte size and write strobes.
REQ-007 inst_addr/inst_wdata  input  32/32  fetch-side address and write data.
REQ-008 inst_addr_ok/inst_data_ok  output  1/1  fetch-side request accepted / response valid.
REQ-009 inst_rdata  output  32  fetch-side read data.
REQ-010 data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: load/store-side port, with widths and directions as in REQ-005..009.
REQ-011 mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  output  1/1/2/4/32/32  shared downstream request.
REQ-012 mem_addr_ok/mem_data_ok  input  1/1  downstream accept / response; mem_rdata  input  32  downstream read data.
REQ-013 outstanding  output  3  current transaction count.
REQ-014 resp_err  output  1  sticky flag: mem_data_ok was seen with no transaction outstanding.

Function
REQ-015 Transfer definition: a request transfers when req and addr_ok are both high in the same cycle; a response occurs in a cycle where data_ok is high.
REQ-016 Grant, default rule: the data port SHALL win over the inst port.
REQ-017 Grant, starvation exception: when the starvation counter equals STARVE_LIMIT and inst_req is high, inst SHALL win.
REQ-018 Lock: while mem_req is high and mem_addr_ok is low, the grant SHALL be registered and held; all mem_* request fields stay sourced from the locked requester until the transfer.
REQ-019 mem_req SHALL equal (selected requester's req) AND (outstanding < MAX_OUTSTANDING).
REQ-020 mem request fields SHALL be a combinational mux of the granted requester.
REQ-021 The granted port's addr_ok SHALL equal mem_addr_ok AND mem_req; the other port's addr_ok SHALL be 0.
REQ-022 On each downstream transfer, the requester ID (0 = inst, 1 = data) SHALL be pushed into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-023 mem_data_ok SHALL pop the FIFO; the port at the FIFO head receives data_ok = 1, and its rdata = mem_rdata, in the same cycle (zero added latency).
REQ-024 The non-head port's rdata SHALL be 0.
REQ-025 Push and pop in the same cycle SHALL leave outstanding unchanged; FIFO pointers wrap modulo depth.
REQ-026 Full FIFO: mem_req = 0, and no addr_ok is asserted.
REQ-027 Full FIFO with a pop in the same cycle: the pop SHALL NOT enable a push in that cycle (mem_req is derived from the registered count).
REQ-028 mem_data_ok with an empty FIFO SHALL be ignored for routing and SHALL set resp_err.
REQ-029 Starvation counter: increments on each data transfer made while inst_req is high; clears on an inst transfer, or when inst_req is low; saturates at STARVE_LIMIT.
REQ-030 Request stability: a requester that deasserts req before its addr_ok is a protocol violation; the arbiter SHALL still release the lock when req drops.

Reset
REQ-031 When resetn = 0 at a clock edge: FIFO empty, outstanding = 0, lock cleared, starvation counter = 0, resp_err = 0.
REQ-032 During reset, all *_addr_ok, *_data_ok and mem_req SHALL be 0, and all rdata outputs SHALL be 0.
REQ-033 Reset mid-transaction SHALL discard outstanding IDs; later mem_data_ok responses set resp_err.

Structure
REQ-034 The requester-ID encoding (INST_ID = 0, DATA_ID = 1) and the SRAM-like bus field widths SHALL live in the shared bus-length header beside the existing pipeline bus widths.
REQ-035 The ID FIFO SHALL be a sub-module named id_fifo, parameterised by depth and width, with push, pop, full, empty, head and count.
REQ-036 Arbitration, lock and the starvation counter SHALL remain in mem_port_arbiter.

Verification
REQ-037 Simultaneous inst and data reads with mem_addr_ok = 1 -> data_addr_ok = 1 first, inst_addr_ok next cycle; responses 0x11111111 and 0x22222222 are routed data-first.
REQ-038 mem_addr_ok = 0 for 3 cycles with data granted, then inst_req rises -> mem_addr stays at the data address until acceptance; inst waits.
REQ-039 Issue 2 reads with no responses -> outstanding = 2, mem_req = 0 in cycle 3; one mem_data_ok -> mem_req resumes the next cycle.
REQ-040 Continuous data_req and inst_req with STARVE_LIMIT = 4 -> grant pattern D,D,D,D,I repeating.
REQ-041 mem_data_ok pulse with outstanding = 0 -> no port data_ok, resp_err = 1 and held until reset.
REQ-042 resetn low for one cycle with 2 outstanding -> outstanding = 0 afterward; a subsequent stray mem_data_ok sets resp_err.
